// File: rtl/dataio_port_arbiter.sv
// Two-requester arbiter for the core data/IO memory port.
// Channel 0 is the execute-stage load/store port, channel 1 the exception
// context push unit. One transaction is outstanding at a time; read data is
// routed back to the channel that issued it and a flush discards in-flight work.
// Optional build macro: DATAIO_PORT_ARBITER_ROUND_ROBIN_EN (round-robin when
// both channels request; fixed priority to channel 0 when undefined).
//
// Handshake: a channel request is taken in the cycle where iCHn_REQ=1 and
// oCHn_BUSY=0; the memory takes oMEM_REQ in the cycle where oMEM_REQ=1 and
// iMEM_BUSY=0. Both requesters hold their request and fields until taken.
module dataio_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iCH0_REQ,
  output logic        oCH0_BUSY,
  input  logic [1:0]  iCH0_ORDER,
  input  logic        iCH0_RW,
  input  logic [31:0] iCH0_ADDR,
  input  logic [31:0] iCH0_DATA,
  output logic        oCH0_VALID,
  output logic [31:0] oCH0_DATA,
  output logic        oCH0_ERR,
  input  logic        iCH1_REQ,
  output logic        oCH1_BUSY,
  input  logic [1:0]  iCH1_ORDER,
  input  logic        iCH1_RW,
  input  logic [31:0] iCH1_ADDR,
  input  logic [31:0] iCH1_DATA,
  output logic        oCH1_VALID,
  output logic [31:0] oCH1_DATA,
  output logic        oCH1_ERR,
  input  logic [31:0] iSYSREG_TIDR,
  input  logic [31:0] iSYSREG_PSR,
  input  logic [31:0] iSYSREG_PDTR,
  output logic        oMEM_REQ,
  input  logic        iMEM_BUSY,
  output logic [1:0]  oMEM_ORDER,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_REQ,
  input  logic [31:0] iMEM_DATA,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam bit       WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic        owner;
  logic [7:0]  timer;
  logic        grant0, grant1, accept, idle_ok;
  logic        timeout_hit;
  logic        ret_fire, ret_err;
  logic [31:0] ret_data;
  logic        ch0_valid_q, ch1_valid_q, ch0_err_q, ch1_err_q;
  logic [31:0] ch0_data_q, ch1_data_q;
  logic [1:0]  lat_order;
  logic        lat_rw;
  logic [31:0] lat_addr, lat_data;
  logic        unused_sysreg;

`ifdef DATAIO_PORT_ARBITER_ROUND_ROBIN_EN
  logic        rr;
  logic        pick1;
`endif

  // Combinational grant: only in IDLE, never during flush or reset.
  always_comb begin
    idle_ok = (state == ST_IDLE) && !iFLUSH && !iRESET_SYNC;
`ifdef DATAIO_PORT_ARBITER_ROUND_ROBIN_EN
    pick1   = iCH1_REQ && (!iCH0_REQ || rr);
    grant1  = idle_ok && pick1;
    grant0  = idle_ok && iCH0_REQ && !pick1;
`else
    grant0  = idle_ok && iCH0_REQ;
    grant1  = idle_ok && iCH1_REQ && !iCH0_REQ;
`endif
    accept  = grant0 || grant1;
  end

  // Watchdog fires on the cycle the timer would reach the configured limit.
  assign timeout_hit = WD_EN && (({1'b0, timer} + 9'd1) == TMO);

  // Next-state and read-return selection; flush outranks responses and timeouts.
  always_comb begin
    state_nxt = state;
    ret_fire  = 1'b0;
    ret_err   = 1'b0;
    ret_data  = 32'h0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!iMEM_BUSY) begin
          if (lat_rw)      state_nxt = ST_IDLE;
          else if (iFLUSH) state_nxt = ST_DRAIN;
          else             state_nxt = ST_WAIT;
        end else if (iFLUSH) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (iFLUSH) begin
          state_nxt = iMEM_REQ ? ST_IDLE : ST_DRAIN;
        end else if (iMEM_REQ) begin
          state_nxt = ST_IDLE;
          ret_fire  = 1'b1;
          ret_data  = iMEM_DATA;
        end else if (timeout_hit) begin
          state_nxt = ST_DRAIN;
          ret_fire  = 1'b1;
          ret_err   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (iMEM_REQ) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, watchdog timer, latched memory fields and channel return registers.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      timer       <= 8'h0;
      lat_order   <= 2'b00;
      lat_rw      <= 1'b0;
      lat_addr    <= 32'h0;
      lat_data    <= 32'h0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      ch0_err_q   <= 1'b0;
      ch1_err_q   <= 1'b0;
      ch0_data_q  <= 32'h0;
      ch1_data_q  <= 32'h0;
    end else begin
      state       <= state_nxt;
      timer       <= ((state == ST_WAIT) && (state_nxt == ST_WAIT)) ? timer + 8'd1 : 8'h0;
      ch0_valid_q <= ret_fire && !owner;
      ch1_valid_q <= ret_fire && owner;
      ch0_err_q   <= ret_fire && !owner && ret_err;
      ch1_err_q   <= ret_fire && owner && ret_err;
      if (ret_fire && !owner) ch0_data_q <= ret_data;
      if (ret_fire && owner)  ch1_data_q <= ret_data;
      if (accept) begin
        owner     <= grant1;
        lat_order <= grant1 ? iCH1_ORDER : iCH0_ORDER;
        lat_rw    <= grant1 ? iCH1_RW    : iCH0_RW;
        lat_addr  <= grant1 ? iCH1_ADDR  : iCH0_ADDR;
        lat_data  <= grant1 ? iCH1_DATA  : iCH0_DATA;
      end
    end
  end

`ifdef DATAIO_PORT_ARBITER_ROUND_ROBIN_EN
  // Round-robin pointer points at the channel not served by the last accept.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) rr <= 1'b0;
    else if (accept) rr <= grant0;
  end
`endif

  assign oCH0_BUSY   = !grant0;
  assign oCH1_BUSY   = !grant1;
  assign oCH0_VALID  = ch0_valid_q;
  assign oCH1_VALID  = ch1_valid_q;
  assign oCH0_ERR    = ch0_err_q;
  assign oCH1_ERR    = ch1_err_q;
  assign oCH0_DATA   = ch0_data_q;
  assign oCH1_DATA   = ch1_data_q;
  assign oMEM_REQ    = (state == ST_ISSUE) && !iRESET_SYNC;
  assign oMEM_ORDER  = lat_order;
  assign oMEM_RW     = lat_rw;
  assign oMEM_ADDR   = lat_addr;
  assign oMEM_DATA   = lat_data;
  assign oMEM_TID    = iSYSREG_TIDR[13:0];
  assign oMEM_MMUMOD = iSYSREG_PSR[1:0];
  assign oMEM_PDT    = iSYSREG_PDTR;
  assign debug_state = state;

  assign unused_sysreg = ^{iSYSREG_TIDR[31:14], iSYSREG_PSR[31:2]};

endmodule

// File: tb/tb_dataio_port_arbiter.sv
// Bench for dataio_port_arbiter: per-cycle vector table plus hand-written
// reset and field sequences. Built with TIMEOUT_CYCLES=8.
module tb_dataio_port_arbiter;

`ifdef DATAIO_PORT_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] D2 = 32'hA5A50001;

  logic        iCLOCK, iRESET_SYNC, iFLUSH;
  logic        iCH0_REQ, oCH0_BUSY, iCH0_RW, oCH0_VALID, oCH0_ERR;
  logic [1:0]  iCH0_ORDER;
  logic [31:0] iCH0_ADDR, iCH0_DATA, oCH0_DATA;
  logic        iCH1_REQ, oCH1_BUSY, iCH1_RW, oCH1_VALID, oCH1_ERR;
  logic [1:0]  iCH1_ORDER;
  logic [31:0] iCH1_ADDR, iCH1_DATA, oCH1_DATA;
  logic [31:0] iSYSREG_TIDR, iSYSREG_PSR, iSYSREG_PDTR;
  logic        oMEM_REQ, iMEM_BUSY, oMEM_RW, iMEM_REQ;
  logic [1:0]  oMEM_ORDER, oMEM_MMUMOD, debug_state;
  logic [13:0] oMEM_TID;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA, iMEM_DATA;

  int n_checks = 0;
  int n_errors = 0;

  dataio_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
    .iCH0_REQ(iCH0_REQ), .oCH0_BUSY(oCH0_BUSY), .iCH0_ORDER(iCH0_ORDER),
    .iCH0_RW(iCH0_RW), .iCH0_ADDR(iCH0_ADDR), .iCH0_DATA(iCH0_DATA),
    .oCH0_VALID(oCH0_VALID), .oCH0_DATA(oCH0_DATA), .oCH0_ERR(oCH0_ERR),
    .iCH1_REQ(iCH1_REQ), .oCH1_BUSY(oCH1_BUSY), .iCH1_ORDER(iCH1_ORDER),
    .iCH1_RW(iCH1_RW), .iCH1_ADDR(iCH1_ADDR), .iCH1_DATA(iCH1_DATA),
    .oCH1_VALID(oCH1_VALID), .oCH1_DATA(oCH1_DATA), .oCH1_ERR(oCH1_ERR),
    .iSYSREG_TIDR(iSYSREG_TIDR), .iSYSREG_PSR(iSYSREG_PSR), .iSYSREG_PDTR(iSYSREG_PDTR),
    .oMEM_REQ(oMEM_REQ), .iMEM_BUSY(iMEM_BUSY), .oMEM_ORDER(oMEM_ORDER),
    .oMEM_RW(oMEM_RW), .oMEM_TID(oMEM_TID), .oMEM_MMUMOD(oMEM_MMUMOD),
    .oMEM_PDT(oMEM_PDT), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_REQ(iMEM_REQ), .iMEM_DATA(iMEM_DATA), .debug_state(debug_state)
  );

  // Clock and global time bound
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end, required finish");
    $fatal(1);
  end

  typedef struct {
    bit          flush;
    bit          r0, w0;
    logic [31:0] a0;
    bit          r1, w1;
    logic [31:0] a1;
    bit          mb, mr;
    logic [31:0] md;
    bit          b0, b1, mq;
    logic [31:0] ma;
    bit          mw, v0, v1, e0;
    logic [31:0] d0;
  } vec_t;

  vec_t tbl [0:79];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic add(input vec_t v);
    tbl[nv] = v;
    nv++;
  endtask

  task automatic idle_inputs();
    iFLUSH = 0; iCH0_REQ = 0; iCH1_REQ = 0; iMEM_BUSY = 0; iMEM_REQ = 0; iMEM_DATA = 0;
  endtask

  initial begin
    // Vector table: inputs for one cycle, expected outputs in that cycle
    // A: CH0 word read, response 3 cycles after memory accept
    add('{L, H,L,32'h1000, L,L,Z, L,L,Z,  L,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h1000,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,H,DB,        H,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, H,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,DB});
    // B: simultaneous writes; loser waits for IDLE
    add('{L, H,H,32'h2000, H,H,32'h3000, L,L,Z,   RR,!RR,L,Z,L, L,L,L,DB});
    add('{L, RR,H,32'h2000, !RR,H,32'h3000, L,L,Z, H,H,H,(RR ? 32'h3000 : 32'h2000),H, L,L,L,DB});
    add('{L, RR,H,32'h2000, !RR,H,32'h3000, L,L,Z, !RR,RR,L,Z,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,(RR ? 32'h2000 : 32'h3000),H, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,DB});
    // C: CH1 write with memory busy for 4 cycles
    add('{L, L,L,Z, H,H,32'h4000, L,L,Z,  H,L,L,Z,L, L,L,L,DB});
    for (int k = 0; k < 4; k++)
      add('{L, L,L,Z, L,L,Z, H,L,Z,       H,H,H,32'h4000,H, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h4000,H, L,L,L,DB});
    add('{L, L,L,Z, H,H,32'h4004, L,L,Z,  H,L,L,Z,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h4004,H, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,DB});
    // D: flush in WAIT_RESP, response drained, next request waits
    add('{L, H,L,32'h5000, L,L,Z, L,L,Z,  L,H,L,Z,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h5000,L, L,L,L,DB});
    add('{H, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,DB});
    add('{L, H,L,32'h6000, L,L,Z, L,L,Z,  H,H,L,Z,L, L,L,L,DB});
    add('{L, H,L,32'h6000, L,L,Z, L,H,32'h12345678, H,H,L,Z,L, L,L,L,DB});
    add('{L, H,L,32'h6000, L,L,Z, L,L,Z,  L,H,L,Z,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h6000,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,H,D2,        H,H,L,Z,L, L,L,L,DB});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, H,L,L,D2});
    // E: watchdog timeout after 8 cycles in WAIT_RESP, late response discarded
    add('{L, H,L,32'h7000, L,L,Z, L,L,Z,  L,H,L,Z,L, L,L,L,D2});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,H,32'h7000,L, L,L,L,D2});
    for (int k = 0; k < 8; k++)
      add('{L, L,L,Z, L,L,Z, L,L,Z,       H,H,L,Z,L, L,L,L,D2});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, H,L,H,Z});
    add('{L, H,L,32'h7004, L,L,Z, L,L,Z,  H,H,L,Z,L, L,L,L,Z});
    add('{L, H,L,32'h7004, L,L,Z, L,H,32'hFFFFFFFF, H,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,Z});
    // F: flush in IDLE blocks the grant
    add('{H, H,L,32'h7008, L,L,Z, L,L,Z,  H,H,L,Z,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,Z});
    // G: flush in ISSUE before memory accept
    add('{L, L,L,Z, H,L,32'h8000, L,L,Z,  H,L,L,Z,L, L,L,L,Z});
    add('{H, L,L,Z, L,L,Z, H,L,Z,         H,H,H,32'h8000,L, L,L,L,Z});
    add('{L, L,L,Z, L,L,Z, L,L,Z,         H,H,L,Z,L, L,L,L,Z});

    // Reset phase with both channels requesting
    iRESET_SYNC = 1; idle_inputs();
    iCH0_REQ = 1; iCH1_REQ = 1;
    iCH0_ORDER = 2'b10; iCH1_ORDER = 2'b01;
    iCH0_RW = 0; iCH1_RW = 0; iCH0_ADDR = 32'h1; iCH1_ADDR = 32'h2;
    iCH0_DATA = 0; iCH1_DATA = 0;
    iSYSREG_TIDR = 32'hFFFFABCD; iSYSREG_PSR = 32'hFFFFFFFE; iSYSREG_PDTR = 32'h12345000;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk1("rst busy0", oCH0_BUSY, 1'b1);
    chk1("rst busy1", oCH1_BUSY, 1'b1);
    chk1("rst mem_req", oMEM_REQ, 1'b0);
    chk1("rst valid0", oCH0_VALID, 1'b0);
    chk1("rst valid1", oCH1_VALID, 1'b0);
    chk1("rst err0", oCH0_ERR, 1'b0);
    chk("rst data0", oCH0_DATA, 32'h0);
    chk("rst data1", oCH1_DATA, 32'h0);
    chk("rst mem_addr", oMEM_ADDR, 32'h0);
    chk("rst mem_data", oMEM_DATA, 32'h0);
    chk("rst mem_order", {30'b0, oMEM_ORDER}, 32'h0);
    chk("rst state", {30'b0, debug_state}, 32'h0);
    chk("tid", {18'b0, oMEM_TID}, 32'h2BCD);
    chk("mmumod", {30'b0, oMEM_MMUMOD}, 32'h2);
    chk("pdt", oMEM_PDT, 32'h12345000);
    iRESET_SYNC = 0; idle_inputs();

    // Driver loop over the vector table
    for (int i = 0; i < nv; i++) begin
      iFLUSH = tbl[i].flush;
      iCH0_REQ = tbl[i].r0; iCH0_RW = tbl[i].w0; iCH0_ADDR = tbl[i].a0; iCH0_DATA = ~tbl[i].a0;
      iCH1_REQ = tbl[i].r1; iCH1_RW = tbl[i].w1; iCH1_ADDR = tbl[i].a1; iCH1_DATA = ~tbl[i].a1;
      iMEM_BUSY = tbl[i].mb; iMEM_REQ = tbl[i].mr; iMEM_DATA = tbl[i].md;
      #2;
      chk1($sformatf("v%0d busy0", i), oCH0_BUSY, tbl[i].b0);
      chk1($sformatf("v%0d busy1", i), oCH1_BUSY, tbl[i].b1);
      chk1($sformatf("v%0d mem_req", i), oMEM_REQ, tbl[i].mq);
      chk1($sformatf("v%0d valid0", i), oCH0_VALID, tbl[i].v0);
      chk1($sformatf("v%0d valid1", i), oCH1_VALID, tbl[i].v1);
      chk1($sformatf("v%0d err0", i), oCH0_ERR, tbl[i].e0);
      chk1($sformatf("v%0d err1", i), oCH1_ERR, 1'b0);
      chk($sformatf("v%0d data0", i), oCH0_DATA, tbl[i].d0);
      chk($sformatf("v%0d data1", i), oCH1_DATA, 32'h0);
      if (tbl[i].mq) begin
        chk($sformatf("v%0d mem_addr", i), oMEM_ADDR, tbl[i].ma);
        chk1($sformatf("v%0d mem_rw", i), oMEM_RW, tbl[i].mw);
        chk($sformatf("v%0d mem_data", i), oMEM_DATA, ~tbl[i].ma);
      end
      @(posedge iCLOCK); #1;
    end
    idle_inputs();

    // Reset asserted mid-ISSUE, then a normal read afterwards
    iCH0_REQ = 1; iCH0_RW = 1; iCH0_ADDR = 32'h9000; iCH0_DATA = 32'h99;
    #2 chk1("rs0 busy0", oCH0_BUSY, 1'b0);
    @(posedge iCLOCK); #1;
    iCH0_REQ = 0; iMEM_BUSY = 1;
    #2;
    chk1("rs1 mem_req", oMEM_REQ, 1'b1);
    chk("rs1 mem_order", {30'b0, oMEM_ORDER}, 32'h2);
    chk("rs1 mem_addr", oMEM_ADDR, 32'h9000);
    iRESET_SYNC = 1;
    #1 chk1("rs1 busy0 in reset", oCH0_BUSY, 1'b1);
    @(posedge iCLOCK); #1;
    iRESET_SYNC = 0; iMEM_BUSY = 0;
    #2;
    chk1("rs2 mem_req", oMEM_REQ, 1'b0);
    chk1("rs2 valid0", oCH0_VALID, 1'b0);
    chk("rs2 state", {30'b0, debug_state}, 32'h0);
    chk("rs2 mem_addr", oMEM_ADDR, 32'h0);
    iCH0_REQ = 1; iCH0_RW = 0; iCH0_ADDR = 32'hA000;
    #1 chk1("rs2 busy0", oCH0_BUSY, 1'b0);
    @(posedge iCLOCK); #1;
    iCH0_REQ = 0;
    #2;
    chk1("rs3 mem_req", oMEM_REQ, 1'b1);
    chk("rs3 mem_addr", oMEM_ADDR, 32'hA000);
    chk1("rs3 mem_rw", oMEM_RW, 1'b0);
    @(posedge iCLOCK); #1;
    iMEM_REQ = 1; iMEM_DATA = 32'h0BADF00D;
    #2 chk("rs4 state", {30'b0, debug_state}, 32'h2);
    @(posedge iCLOCK); #1;
    iMEM_REQ = 0;
    #2;
    chk1("rs5 valid0", oCH0_VALID, 1'b1);
    chk("rs5 data0", oCH0_DATA, 32'h0BADF00D);
    chk1("rs5 err0", oCH0_ERR, 1'b0);
    chk1("rs5 valid1", oCH1_VALID, 1'b0);
    chk("rs5 state", {30'b0, debug_state}, 32'h0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dataio_port_arbiter.md
Name: dataio_port_arbiter

Overview:
- Shares the single core data/IO memory port between two requesters.
- Channel 0 is the execute-stage load/store port; channel 1 is the exception/interrupt context push unit.
- One transaction is outstanding at a time. Read responses are routed back to the owning channel, and a flush discards any in-flight work.
- Sits between the execute ports and the L1 data / MMU interface.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for a read response before forcing completion; 0 disables the watchdog (8-bit counter, legal range 0-255)

Ports:
iCLOCK  in  1  core clock; the block runs on one clock only
iRESET_SYNC  in  1  reset, synchronous and active-high
iFLUSH  in  1  pipeline flush; abort/discard current transaction
iCHn_REQ  in  1  channel n request (n=0,1), held high until accepted
oCHn_BUSY  out  1  channel n not accepted this cycle
iCHn_ORDER  in  2  00 byte, 01 half, 10 word
iCHn_RW  in  1  0 read, 1 write
iCHn_ADDR  in  32  byte address
iCHn_DATA  in  32  write data
oCHn_VALID  out  1  one-cycle read-data return pulse for channel n
oCHn_DATA  out  32  read data for channel n
oCHn_ERR  out  1  with oCHn_VALID: watchdog timeout, data forced 0
iSYSREG_TIDR  in  32  TID source, bits [13:0] used
iSYSREG_PSR  in  32  MMU mode source, bits [1:0] used
iSYSREG_PDTR  in  32  page directory base
oMEM_REQ  out  1  memory request, held until accepted
iMEM_BUSY  in  1  memory cannot accept this cycle
oMEM_ORDER  out  2  latched order
oMEM_RW  out  1  latched direction
oMEM_TID  out  14  iSYSREG_TIDR[13:0], combinational
oMEM_MMUMOD  out  2  iSYSREG_PSR[1:0], combinational
oMEM_PDT  out  32  iSYSREG_PDTR, combinational
oMEM_ADDR  out  32  latched address
oMEM_DATA  out  32  latched write data
iMEM_REQ  in  1  read response valid
iMEM_DATA  in  32  read response data

Behaviour:
- Reset (sync, active-high, highest priority over flush and all events):
  - state=IDLE, owner=0, rr pointer=0, timer=0.
  - oMEM_REQ=0; all latched MEM fields=0.
  - oCHn_VALID=0, oCHn_ERR=0, oCHn_DATA=0.
  - oCHn_BUSY=1 while reset is asserted.
- Handshake: a channel request is accepted in the cycle where iCHn_REQ=1 and oCHn_BUSY=0. The requester drops REQ or presents the next request after that cycle.
- IDLE:
  - oCHn_BUSY = !(grant_n); grant is combinational.
  - Default policy is fixed priority, channel 0 wins.
  - On accept: latch ORDER/RW/ADDR/DATA and owner, then go to ISSUE. oMEM_REQ=1 from the next cycle (1-cycle latency).
  - The losing channel sees BUSY=1.
  - iFLUSH=1 in IDLE: no grant that cycle; both BUSY=1.
- ISSUE: oMEM_REQ=1 and MEM fields stable while iMEM_BUSY=1. On !iMEM_BUSY the memory accepts; oMEM_REQ=0 next cycle.
  - Write: go to IDLE; no channel return pulse.
  - Read: go to WAIT_RESP; timer=0.
- WAIT_RESP:
  - On iMEM_REQ: oCH{owner}_VALID=1 for one cycle, registered. oCH{owner}_DATA=iMEM_DATA, ERR=0. Go to IDLE.
  - Otherwise timer increments. When TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES: VALID=1, ERR=1, DATA=0; go to DRAIN.
- DRAIN: wait for iMEM_REQ and discard it, then go to IDLE. Watchdog not active here.
- Flush:
  - In ISSUE, before memory accept: drop oMEM_REQ next cycle, go to IDLE.
  - In ISSUE on the accept cycle:
    - Write: completes; go to IDLE.
    - Read: go to DRAIN.
  - In WAIT_RESP: go to DRAIN, no VALID pulse. If iMEM_REQ arrives in the same cycle as the flush, the response is discarded and the state goes to IDLE.
- All channel BUSY=1 outside IDLE.
- oCHn_DATA holds its last value between pulses.
- oMEM_RW/ORDER/ADDR/DATA change only on accept.

Optional Feature:
DATAIO_PORT_ARBITER_ROUND_ROBIN_EN:
- Defined: when both channels request in IDLE, the channel indicated by the rr pointer wins. On each accept the pointer moves to the other channel. A single requester always wins regardless of the pointer.
- Undefined: fixed priority, channel 0 always wins. The rr pointer logic is absent.

Test Plan:
- CH0 read addr 0x00001000 word, iMEM_BUSY=0, response 0xDEADBEEF 3 cycles after accept -> oMEM_REQ high exactly 1 cycle, oMEM_ADDR=0x00001000, RW=0; oCH0_VALID 1 cycle, DATA=0xDEADBEEF, ERR=0, CH1 never pulses.
- CH0 and CH1 writes requested same cycle, fixed priority -> CH0 accepted first, CH1 BUSY=1 until IDLE returns; two memory writes in order CH0 then CH1. With ROUND_ROBIN_EN after a prior CH0 accept -> CH1 first.
- CH1 write, iMEM_BUSY=1 for 4 cycles -> oMEM_REQ and fields stable 5 cycles; returns to IDLE the cycle after the busy drop; no VALID.
- CH0 read accepted by memory, iFLUSH in WAIT_RESP, response arrives 2 cycles later -> no oCH0_VALID; next CH0 request is not granted until the response is drained.
- TIMEOUT_CYCLES=8, read with no response -> 8 cycles after entering WAIT_RESP, oCH0_VALID=1, ERR=1, DATA=0; a later response is discarded.
- Assert iRESET_SYNC mid-ISSUE -> next cycle oMEM_REQ=0, all VALID=0, state IDLE; a request after reset deasserts is serviced normally.
